// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register bank: FSM states, R/W bit values
// and the default byte returned for unmapped reads.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PTR   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } regbank_state_t;

    localparam logic       RW_READ             = 1'b1;
    localparam logic       RW_WRITE            = 1'b0;
    localparam logic [7:0] UNMAPPED_RD_DEFAULT = 8'hFF;

endpackage

// File: rtl/i2c_regbank_rdmux.sv
// Registered read mux from the register pointer to the byte offered to the slave.
// With I2C_REGBANK_SNAPSHOT_EN defined, reads during RDATA come from a shadow bank.
module i2c_regbank_rdmux
    import i2c_pkg::*;
#(
    parameter int         NUM_WR      = 4,
    parameter int         NUM_RD      = 4,
    parameter int         PTR_W       = 3,
    parameter logic [7:0] UNMAPPED_RD = UNMAPPED_RD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PTR_W-1:0]    ptr,
    input  logic [8*NUM_WR-1:0] ctrl_regs,
    input  logic [8*NUM_RD-1:0] status_regs,
`ifdef I2C_REGBANK_SNAPSHOT_EN
    input  logic                snap_stb,
    input  logic                rd_active,
`endif
    output logic [7:0]          data_tx
);

    logic [8*NUM_RD-1:0] rd_src;
    logic [7:0]          next_tx;

`ifdef I2C_REGBANK_SNAPSHOT_EN
    logic [8*NUM_RD-1:0] shadow;

    // Shadow is frozen at the read address so a multi-byte read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (snap_stb) begin
            shadow <= status_regs;
        end
    end

    assign rd_src = rd_active ? shadow : status_regs;
`else
    assign rd_src = status_regs;
`endif

    // Equality against every mapped address leaves out-of-map pointers on the default.
    always_comb begin
        next_tx = UNMAPPED_RD;
        for (int k = 0; k < NUM_WR; k++) begin
            if (ptr == PTR_W'(k)) next_tx = ctrl_regs[8*k +: 8];
        end
        for (int k = 0; k < NUM_RD; k++) begin
            if (ptr == PTR_W'(NUM_WR + k)) next_tx = rd_src[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_tx <= UNMAPPED_RD;
        end else begin
            data_tx <= next_tx;
        end
    end

endmodule

// File: rtl/i2c_register_bank.sv
// Pointer-addressed register bank behind the i2c_simple_slave byte interface.
// Optional status snapshot on read address: define I2C_REGBANK_SNAPSHOT_EN.
module i2c_register_bank
    import i2c_pkg::*;
#(
    parameter int         NUM_WR      = 4,
    parameter int         NUM_RD      = 4,
    parameter logic [7:0] CTRL_RESET  = 8'h00,
    parameter logic [7:0] UNMAPPED_RD = UNMAPPED_RD_DEFAULT,
    localparam int        TOTAL       = NUM_WR + NUM_RD,
    localparam int        PTR_W       = ($clog2(TOTAL) > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i2c_addr_rw,
    input  logic                i2c_addr_rw_valid_stb,
    input  logic [7:0]          i2c_data_rx,
    input  logic                i2c_data_rx_valid_stb,
    output logic [7:0]          i2c_data_tx,
    input  logic                i2c_data_tx_loaded_stb,
    input  logic                i2c_error_stb,
    output logic [8*NUM_WR-1:0] ctrl_regs,
    output logic [NUM_WR-1:0]   ctrl_wr_stb,
    input  logic [8*NUM_RD-1:0] status_regs,
    output logic [PTR_W-1:0]    ptr,
    output logic [1:0]          debug_state
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TOTAL - 1);

    regbank_state_t          state;
    logic [NUM_WR-1:0][7:0]  ctrl_q;
    logic [PTR_W-1:0]        next_ptr;
    logic                    unused_addr_bits;

    // Address matching is the slave's job; only the R/W bit matters here.
    assign unused_addr_bits = ^i2c_addr_rw[7:1];

    assign next_ptr    = (ptr >= LAST_PTR) ? '0 : ptr + PTR_W'(1);
    assign ctrl_regs   = ctrl_q;
    assign debug_state = state;

    // An address strobe overrides a coincident error; an error drops a coincident byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            ctrl_q      <= {NUM_WR{CTRL_RESET}};
            ctrl_wr_stb <= '0;
        end else begin
            ctrl_wr_stb <= '0;
            if (i2c_addr_rw_valid_stb) begin
                state <= (i2c_addr_rw[0] == RW_WRITE) ? ST_PTR : ST_RDATA;
            end else if (i2c_error_stb) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_PTR: begin
                        if (i2c_data_rx_valid_stb) begin
                            ptr   <= i2c_data_rx[PTR_W-1:0];
                            state <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (i2c_data_rx_valid_stb) begin
                            for (int k = 0; k < NUM_WR; k++) begin
                                if (ptr == PTR_W'(k)) begin
                                    ctrl_q[k]      <= i2c_data_rx;
                                    ctrl_wr_stb[k] <= 1'b1;
                                end
                            end
                            ptr <= next_ptr;
                        end
                    end
                    ST_RDATA: begin
                        if (i2c_data_tx_loaded_stb) ptr <= next_ptr;
                    end
                    default: ;
                endcase
            end
        end
    end

    i2c_regbank_rdmux #(
        .NUM_WR      (NUM_WR),
        .NUM_RD      (NUM_RD),
        .PTR_W       (PTR_W),
        .UNMAPPED_RD (UNMAPPED_RD)
    ) u_rdmux (
        .clk         (clk),
        .rst_n       (rst_n),
        .ptr         (ptr),
        .ctrl_regs   (ctrl_q),
        .status_regs (status_regs),
`ifdef I2C_REGBANK_SNAPSHOT_EN
        .snap_stb    (i2c_addr_rw_valid_stb && (i2c_addr_rw[0] == RW_READ)),
        .rd_active   (state == ST_RDATA),
`endif
        .data_tx     (i2c_data_tx)
    );

endmodule
